cnn_layer_accel_pixel_fetcher: RTL
==================================

# cnn_layer_accel_pixel_fetcher

Host-side responder for the quad's job-fetch/pixel interface. Answers each `job_fetch_request` with an ack, streams one input-map row (`cfg_num_cols` packed pixel words) from a single-port read memory over `pixel_valid`/`pixel_ready`, then pulses `job_fetch_complete`. After `cfg_num_rows` rows it signals `done`. Sits between the frame-buffer read port and `cnn_layer_accel_quad` in the `clk_if` domain, replacing bench-driven pixel stimulus.

## Interface
- `C_PIXEL_WIDTH`, 16, bits per depth lane
- `C_NUM_LANES`, 8, depth lanes packed per word; lane 0 in bits [C_PIXEL_WIDTH-1:0]
- `C_ADDR_WIDTH`, 16, memory word-address width
- `C_DIM_WIDTH`, 10, width of row/col counts
- `clk_if` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset
- `cfg_start` in 1: pulse; latches cfg_* and starts a frame when idle
- `cfg_num_rows` in C_DIM_WIDTH: rows per frame
- `cfg_num_cols` in C_DIM_WIDTH: words per row
- `cfg_base_addr` in C_ADDR_WIDTH: word address of row 0, col 0
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse at end of frame
- `job_fetch_request` in 1: quad requests one row
- `job_fetch_ack` out 1: one-cycle ack
- `job_fetch_complete` out 1: one-cycle pulse after last beat of row
- `pixel_valid` out 1; `pixel_ready` in 1
- `pixel_data` out C_PIXEL_WIDTH*C_NUM_LANES
- `mem_rd_en` out 1; `mem_rd_addr` out C_ADDR_WIDTH
- `mem_rd_data` in C_PIXEL_WIDTH*C_NUM_LANES: valid exactly 1 cycle after `mem_rd_en`

## Operation
- States: IDLE, WAIT_REQ, ACK, STREAM, COMPLETE, DONE.
- IDLE: `cfg_start`=1 latches cfg, loads address counter = `cfg_base_addr`, row counter = 0. If rows==0 or cols==0 -> DONE, else -> WAIT_REQ. `cfg_start` ignored in every other state.
- WAIT_REQ: `job_fetch_request`=1 sampled -> ACK. Requests in other states ignored (not queued).
- ACK: `job_fetch_ack`=1 this cycle only; column counter cleared; -> STREAM.
- Read issue (ACK and STREAM): `mem_rd_en`=1 when reads-remaining-in-row > 0 and (buffer occupancy + in-flight reads) < 2; address counter increments per read, continuous across rows (row r, col c at base + r*cols + c; wraps modulo 2^C_ADDR_WIDTH).
- Returned data enters 2-entry skid buffer; head drives `pixel_data`; `pixel_valid` = buffer non-empty.
- Beat transfers on `pixel_valid & pixel_ready`. `pixel_data` stable while valid & !ready.
- On transfer of beat cols-1 -> COMPLETE. Exactly `cfg_num_cols` beats per fetch.
- COMPLETE: `job_fetch_complete`=1 one cycle, `pixel_valid`=0; row counter++; if row counter == rows -> DONE else -> WAIT_REQ.
- DONE: `done`=1 one cycle -> IDLE.
- `busy` = state != IDLE.

## Timing
- Reset: all outputs 0, buffer emptied, in-flight reads discarded, state IDLE. Reset mid-row aborts; no complete/done emitted.
- Request sampled at edge N -> `job_fetch_ack` high cycle N+1 -> first read issued N+1 -> `pixel_valid` high N+2.
- With `pixel_ready` held 1: one beat per cycle, no bubbles; row of C words occupies cycles N+2..N+C+1; `job_fetch_complete` at N+C+2.
- Ready deasserted: no reads issued beyond 2-entry capacity; no data lost or duplicated; resumes 1 beat/cycle on ready.
- Request still high during COMPLETE: re-sampled in WAIT_REQ; next ack no earlier than 2 cycles after complete.
- Last row: `done` one cycle after final `job_fetch_complete`.
- Counters: column/row compare at full C_DIM_WIDTH; max 2^C_DIM_WIDTH-1.

## Structure
- Package `cnn_layer_accel_fetch_pkg`: state enum, word-width constant (C_PIXEL_WIDTH*C_NUM_LANES), skid depth constant (2).
- Sub-module `cnn_layer_accel_skid_buf`: 2-entry FIFO, push/pop/occupancy, synchronous clear; FSM, counters and read-issue logic in top.

## Test plan
- rows=10, cols=10, base=0, memory word k = k in every lane, quad model ready=1 -> 10 ack/complete pairs, 100 beats with data 0..99 in order, 10 beats per fetch, `done` once after 10th complete.
- Same frame, `pixel_ready` random 50% -> identical data sequence, `pixel_data` stable across stalls, never >2 reads in flight.
- Request held high continuously -> one ack per row, acks separated by ≥ cols+3 cycles, exactly 10 rows.
- rows=0 or cols=0 with `cfg_start` -> `done` at cycle 2 after start, no ack, no `mem_rd_en`.
- `rst` asserted mid-row 3 -> next cycle all outputs 0, IDLE; new `cfg_start` base=0x40 restarts from word 0x40.
- base=0xFFFC, rows=1, cols=8 -> addresses FFFC..FFFF,0000..0003 in order.

Source files
------------

// File: rtl/cnn_layer_accel_fetch_pkg.sv
// Shared types and constants for the quad pixel fetcher.
// State encoding, word width and skid depth.
package cnn_layer_accel_fetch_pkg;

  localparam int C_PIXEL_WIDTH_D = 16;
  localparam int C_NUM_LANES_D   = 8;
  localparam int C_WORD_WIDTH    = C_PIXEL_WIDTH_D * C_NUM_LANES_D;
  localparam int C_SKID_DEPTH    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_ACK,
    S_STREAM,
    S_COMPLETE,
    S_DONE
  } fetch_state_t;

endpackage

// File: rtl/cnn_layer_accel_skid_buf.sv
// Two-entry FIFO holding returned pixel words.
// Push/pop may coincide; clear is synchronous.
module cnn_layer_accel_skid_buf
  import cnn_layer_accel_fetch_pkg::*;
#(
  parameter int W = C_WORD_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_occ,
  output logic         o_empty
);

  localparam int PW = $clog2(C_SKID_DEPTH);

  logic [W-1:0]  r_mem [C_SKID_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [1:0]    r_occ;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;
  assign o_empty = (r_occ == 2'd0);

endmodule

// File: rtl/cnn_layer_accel_pixel_fetcher.sv
// Job-fetch responder: acks row requests and streams
// one row of packed pixel words from a 1-cycle read memory.
module cnn_layer_accel_pixel_fetcher
  import cnn_layer_accel_fetch_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_NUM_LANES   = 8,
  parameter int C_ADDR_WIDTH  = 16,
  parameter int C_DIM_WIDTH   = 10
) (
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [C_DIM_WIDTH-1:0] cfg_num_rows,
  input  logic [C_DIM_WIDTH-1:0] cfg_num_cols,
  input  logic [C_ADDR_WIDTH-1:0] cfg_base_addr,
  output logic                   busy,
  output logic                   done,
  input  logic                   job_fetch_request,
  output logic                   job_fetch_ack,
  output logic                   job_fetch_complete,
  output logic                   pixel_valid,
  input  logic                   pixel_ready,
  output logic [C_PIXEL_WIDTH*C_NUM_LANES-1:0] pixel_data,
  output logic                   mem_rd_en,
  output logic [C_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [C_PIXEL_WIDTH*C_NUM_LANES-1:0] mem_rd_data
);

  localparam int W = C_PIXEL_WIDTH * C_NUM_LANES;
  localparam logic [C_DIM_WIDTH-1:0]  L_D1 = 1;
  localparam logic [C_ADDR_WIDTH-1:0] L_A1 = 1;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [C_DIM_WIDTH-1:0]  r_rows;
  logic [C_DIM_WIDTH-1:0]  r_cols;
  logic [C_DIM_WIDTH-1:0]  r_row_cnt;
  logic [C_DIM_WIDTH-1:0]  r_rd_cnt;
  logic [C_DIM_WIDTH-1:0]  r_beat_cnt;
  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic                    r_inflight;

  logic                   w_stream;
  logic                   w_rd_en;
  logic                   w_pv;
  logic                   w_xfer;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_last;
  logic [1:0]             w_occ;
  logic [1:0]             w_level;
  logic                   w_buf_empty;
  logic [W-1:0]           w_buf_dout;
  logic [C_DIM_WIDTH-1:0] w_row_nxt;

  assign w_stream  = (r_state == S_ACK) || (r_state == S_STREAM);
  assign w_level   = w_occ + 2'(r_inflight);
  assign w_rd_en   = w_stream && (r_rd_cnt < r_cols)
                   && (w_level < 2'(C_SKID_DEPTH));
  // Memory output acts as a fall-through stage ahead of the buffer.
  assign w_pv      = w_stream && (!w_buf_empty || r_inflight);
  assign w_xfer    = w_pv && pixel_ready;
  assign w_push    = r_inflight && !(w_buf_empty && pixel_ready);
  assign w_pop     = !w_buf_empty && w_xfer;
  assign w_last    = (r_beat_cnt == (r_cols - L_D1));
  assign w_row_nxt = r_row_cnt + L_D1;

  cnn_layer_accel_skid_buf #(.W(W)) u_skid (
    .i_clk   (clk_if),
    .i_clr   (rst),
    .i_push  (w_push),
    .i_din   (mem_rd_data),
    .i_pop   (w_pop),
    .o_dout  (w_buf_dout),
    .o_occ   (w_occ),
    .o_empty (w_buf_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          if ((cfg_num_rows == '0) || (cfg_num_cols == '0))
            w_state_nxt = S_DONE;
          else
            w_state_nxt = S_WAIT_REQ;
        end
      end
      S_WAIT_REQ: if (job_fetch_request) w_state_nxt = S_ACK;
      S_ACK:      w_state_nxt = S_STREAM;
      S_STREAM:   if (w_xfer && w_last) w_state_nxt = S_COMPLETE;
      S_COMPLETE: begin
        if (w_row_nxt == r_rows) w_state_nxt = S_DONE;
        else                     w_state_nxt = S_WAIT_REQ;
      end
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_if) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rows     <= '0;
      r_cols     <= '0;
      r_addr     <= '0;
      r_row_cnt  <= '0;
      r_rd_cnt   <= '0;
      r_beat_cnt <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      if ((r_state == S_IDLE) && cfg_start) begin
        r_rows    <= cfg_num_rows;
        r_cols    <= cfg_num_cols;
        r_addr    <= cfg_base_addr;
        r_row_cnt <= '0;
      end else if (w_rd_en) begin
        r_addr <= r_addr + L_A1;
      end
      if (!w_stream) begin
        r_rd_cnt   <= '0;
        r_beat_cnt <= '0;
      end else begin
        if (w_rd_en) r_rd_cnt   <= r_rd_cnt + L_D1;
        if (w_xfer)  r_beat_cnt <= r_beat_cnt + L_D1;
      end
      if (r_state == S_COMPLETE) r_row_cnt <= w_row_nxt;
    end
  end

  assign busy               = (r_state != S_IDLE);
  assign done               = (r_state == S_DONE);
  assign job_fetch_ack      = (r_state == S_ACK);
  assign job_fetch_complete = (r_state == S_COMPLETE);
  assign pixel_valid        = w_pv;
  assign pixel_data         = !w_pv ? '0
                            : (w_buf_empty ? mem_rd_data : w_buf_dout);
  assign mem_rd_en          = w_rd_en;
  assign mem_rd_addr        = w_rd_en ? r_addr : '0;

endmodule
